// File: rtl/fpdivsqrt_multi_unit_ctrl.sv
// Dispatch/collect controller presenting NUM_UNITS divsqrt units as one in-order unit.
// Requests go round-robin to a free unit; an order FIFO of unit indices retires results in acceptance order.
module fpdivsqrt_multi_unit_ctrl #(
  parameter int NUM_UNITS = 4,
  parameter int UIDX_W    = $clog2(NUM_UNITS),
  parameter int CNT_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    start_valid_i,
  output logic                    start_ready_o,
  input  logic [1:0]              fp_format_i,
  input  logic                    is_fdiv_i,
  input  logic [63:0]             opa_i,
  input  logic [63:0]             opb_i,
  input  logic [2:0]              rm_i,
  output logic                    finish_valid_o,
  input  logic                    finish_ready_i,
  output logic [63:0]             fdivsqrt_res_o,
  output logic [4:0]              fflags_o,
  output logic [NUM_UNITS-1:0]    unit_start_valid_o,
  input  logic [NUM_UNITS-1:0]    unit_start_ready_i,
  output logic                    unit_flush_o,
  input  logic [NUM_UNITS-1:0]    unit_finish_valid_i,
  output logic [NUM_UNITS-1:0]    unit_finish_ready_o,
  input  logic [64*NUM_UNITS-1:0] unit_res_i,
  input  logic [5*NUM_UNITS-1:0]  unit_fflags_i,
  output logic [CNT_W-1:0]        inflight_cnt_o,
  output logic                    protocol_err_o
);

  logic [UIDX_W-1:0]    fifo [NUM_UNITS];
  logic [UIDX_W-1:0]    wr_ptr;
  logic [UIDX_W-1:0]    rd_ptr;
  logic [UIDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]     count;
  logic [NUM_UNITS-1:0] outstanding;
  logic                 err;

  logic [UIDX_W-1:0]    sel;
  logic [UIDX_W-1:0]    head;
  logic                 has_entry;
  logic                 accept;
  logic                 retire;
  logic                 stray_finish;
  logic [NUM_UNITS-1:0] retire_mask;

  // Operands and mode fan out to the units directly from the issue bus.
  logic unused_bcast;
  assign unused_bcast = ^{fp_format_i, is_fdiv_i, opa_i, opb_i, rm_i};

  function automatic logic [UIDX_W-1:0] wrap_inc(input logic [UIDX_W-1:0] p);
    if (p == UIDX_W'(NUM_UNITS - 1)) return '0;
    return p + UIDX_W'(1);
  endfunction

  always_comb begin : sel_logic
    logic                found;
    logic [UIDX_W-1:0]   idx;
    found = 1'b0;
    sel   = rr_ptr;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && unit_start_ready_i[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

  assign has_entry     = (count != '0);
  assign start_ready_o = !flush_i && (|unit_start_ready_i) && (count != CNT_W'(NUM_UNITS));
  assign accept        = start_valid_i && start_ready_o;
  assign head          = fifo[rd_ptr];

  assign finish_valid_o = has_entry && unit_finish_valid_i[head] && !flush_i;
  assign retire         = finish_valid_o && finish_ready_i;
  assign retire_mask    = unit_finish_ready_o & {NUM_UNITS{finish_valid_o}};

  assign unit_flush_o   = flush_i;
  assign inflight_cnt_o = count;
  assign protocol_err_o = err;

  assign stray_finish = (|(unit_finish_valid_i & ~outstanding)) && !flush_i;

  always_comb begin
    unit_start_valid_o  = '0;
    unit_finish_ready_o = '0;
    fdivsqrt_res_o      = '0;
    fflags_o            = '0;
    unit_start_valid_o[sel]   = accept;
    unit_finish_ready_o[head] = finish_ready_i && has_entry && !flush_i;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (head == UIDX_W'(k)) begin
        fdivsqrt_res_o = unit_res_i[64*k +: 64];
        fflags_o       = unit_fflags_i[5*k +: 5];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_UNITS; k++) fifo[k] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (stray_finish) err <= 1'b1;
      if (flush_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        rr_ptr      <= '0;
        count       <= '0;
        outstanding <= '0;
      end else begin
        if (accept) begin
          fifo[wr_ptr] <= sel;
          wr_ptr       <= wrap_inc(wr_ptr);
          rr_ptr       <= wrap_inc(sel);
        end
        if (retire) rd_ptr <= wrap_inc(rd_ptr);
        // Dispatch wins over retire so a unit reused in the same cycle stays marked.
        outstanding <= (outstanding & ~retire_mask) | unit_start_valid_o;
        case ({accept, retire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpdivsqrt_multi_unit_ctrl.sv
// Scoreboard bench for fpdivsqrt_multi_unit_ctrl with simple latency-programmable unit models.
module tb_fpdivsqrt_multi_unit_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          start_valid_i = 1'b0;
  logic          start_ready_o;
  logic [1:0]    fp_format_i = 2'b01;
  logic          is_fdiv_i = 1'b1;
  logic [63:0]   opa_i = '0;
  logic [63:0]   opb_i = '0;
  logic [2:0]    rm_i = 3'd0;
  logic          finish_valid_o;
  logic          finish_ready_i = 1'b1;
  logic [63:0]   fdivsqrt_res_o;
  logic [4:0]    fflags_o;
  logic [N-1:0]  unit_start_valid_o;
  logic [N-1:0]  unit_start_ready_i;
  logic          unit_flush_o;
  logic [N-1:0]  unit_finish_valid_i;
  logic [N-1:0]  unit_finish_ready_o;
  logic [64*N-1:0] unit_res_i;
  logic [5*N-1:0]  unit_fflags_i;
  logic [2:0]    inflight_cnt_o;
  logic          protocol_err_o;

  fpdivsqrt_multi_unit_ctrl #(.NUM_UNITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .fp_format_i(fp_format_i), .is_fdiv_i(is_fdiv_i), .opa_i(opa_i), .opb_i(opb_i), .rm_i(rm_i),
    .finish_valid_o(finish_valid_o), .finish_ready_i(finish_ready_i),
    .fdivsqrt_res_o(fdivsqrt_res_o), .fflags_o(fflags_o),
    .unit_start_valid_o(unit_start_valid_o), .unit_start_ready_i(unit_start_ready_i),
    .unit_flush_o(unit_flush_o), .unit_finish_valid_i(unit_finish_valid_i),
    .unit_finish_ready_o(unit_finish_ready_o), .unit_res_i(unit_res_i),
    .unit_fflags_i(unit_fflags_i), .inflight_cnt_o(inflight_cnt_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  // Unit models: accept when idle, finish nlat cycles later, hold result until handshake.
  logic [N-1:0] busy, fv, block, stray;
  int           cnt [N];
  logic [63:0]  ures [N];
  logic [4:0]   uflg [N];
  logic [63:0]  nres;
  logic [4:0]   nflg;
  int           nlat;

  assign unit_start_ready_i  = ~busy & ~block;
  assign unit_finish_valid_i = fv | stray;
  assign unit_res_i    = {ures[3], ures[2], ures[1], ures[0]};
  assign unit_fflags_i = {uflg[3], uflg[2], uflg[1], uflg[0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      fv   <= '0;
      for (int k = 0; k < N; k++) begin
        cnt[k]  <= 0;
        ures[k] <= '0;
        uflg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (unit_flush_o) begin
          busy[k] <= 1'b0;
          fv[k]   <= 1'b0;
        end else if (unit_start_valid_o[k] && unit_start_ready_i[k]) begin
          busy[k] <= 1'b1;
          fv[k]   <= 1'b0;
          cnt[k]  <= nlat;
          ures[k] <= nres;
          uflg[k] <= nflg;
        end else if (fv[k] && unit_finish_ready_o[k]) begin
          busy[k] <= 1'b0;
          fv[k]   <= 1'b0;
        end else if (busy[k] && !fv[k]) begin
          if (cnt[k] <= 1) fv[k] <= 1'b1;
          else cnt[k] <= cnt[k] - 1;
        end
      end
    end
  end

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    int          unit;
  } exp_t;

  exp_t sbq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every retire handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && finish_valid_o && finish_ready_i) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL retire_unexpected: got result %h, expected no retire", fdivsqrt_res_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("retire_res", fdivsqrt_res_o, e.res);
        chk("retire_flags", 64'(fflags_o), 64'(e.flg));
        chk("retire_head_onehot", 64'(unit_finish_ready_o), 64'(1 << e.unit));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    flush_i = 1'b0;
    start_valid_i = 1'b0;
    finish_ready_i = 1'b1;
    block = '0;
    stray = '0;
    sbq.delete();
    repeat (2) @(negedge clk);
    chk("rst_finish_valid", 64'(finish_valid_o), 64'd0);
    chk("rst_unit_finish_ready", 64'(unit_finish_ready_o), 64'd0);
    chk("rst_unit_start_valid", 64'(unit_start_valid_o), 64'd0);
    chk("rst_inflight", 64'(inflight_cnt_o), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [63:0] r, input logic [4:0] f, input int eu, input int lat,
                       input bit stall);
    int w;
    w = 0;
    opa_i = r ^ 64'h0123_4567_89ab_cdef;
    opb_i = ~r;
    nres = r;
    nflg = f;
    nlat = lat;
    start_valid_i = 1'b1;
    @(negedge clk);
    if (stall) chk("stall_ready", 64'(start_ready_o), 64'd0);
    while (!start_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!start_ready_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: start_ready_o stayed %b, expected 1", start_ready_o);
    end else begin
      chk("dispatch_onehot", 64'(unit_start_valid_o), 64'(1 << eu));
      sbq.push_back('{r, f, eu});
    end
    @(posedge clk);
    #1;
    start_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", nm, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    chk({nm, "_inflight_zero"}, 64'(inflight_cnt_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Single fdiv 1.0/3.0, FP64
    do_reset();
    issue(64'h3FD5555555555555, 5'b00001, 0, 5, 1'b0);
    @(negedge clk);
    chk("t1_inflight_one", 64'(inflight_cnt_o), 64'd1);
    drain("t1");

    // Four back-to-back, out-of-order finish 2,0,3,1, fifth stalls then wraps to unit 0
    do_reset();
    issue(64'h4000_0000_0000_0000, 5'b00000, 0, 6, 1'b0);
    issue(64'h4010_0000_0000_0001, 5'b00001, 1, 9, 1'b0);
    issue(64'h4020_0000_0000_0002, 5'b00010, 2, 2, 1'b0);
    issue(64'h4030_0000_0000_0003, 5'b01000, 3, 5, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!unit_finish_valid_i[2] && w < 50);
    chk("t2_unit2_done", 64'(unit_finish_valid_i[2]), 64'd1);
    chk("t2_hold_not_head", 64'(finish_valid_o), 64'd0);
    chk("t2_ready_on_head", 64'(unit_finish_ready_o), 64'b0001);
    chk("t2_inflight_full", 64'(inflight_cnt_o), 64'd4);
    @(posedge clk);
    #1;
    issue(64'h4040_0000_0000_0004, 5'b10000, 0, 3, 1'b1);
    drain("t2");

    // Round-robin skip and wrap
    do_reset();
    issue(64'h1111_0000_0000_0000, 5'b00001, 0, 1, 1'b0);
    issue(64'h2222_0000_0000_0000, 5'b00010, 1, 1, 1'b0);
    drain("t4a");
    block = 4'b0100;
    issue(64'h3333_0000_0000_0000, 5'b00100, 3, 1, 1'b0);
    drain("t4b");
    block = 4'b0000;
    issue(64'h4444_0000_0000_0000, 5'b01000, 0, 1, 1'b0);
    issue(64'h5555_0000_0000_0000, 5'b10000, 1, 1, 1'b0);
    drain("t4c");
    block = 4'b1110;
    issue(64'h6666_0000_0000_0000, 5'b00011, 0, 1, 1'b0);
    drain("t4d");
    block = 4'b0000;

    // Retire and accept in the same cycle
    do_reset();
    finish_ready_i = 1'b0;
    issue(64'hAAAA_0000_0000_0000, 5'b00001, 0, 1, 1'b0);
    issue(64'hBBBB_0000_0000_0000, 5'b00010, 1, 20, 1'b0);
    issue(64'hCCCC_0000_0000_0000, 5'b00100, 2, 20, 1'b0);
    nres = 64'hDDDD_0000_0000_0000;
    nflg = 5'b01000;
    nlat = 5;
    start_valid_i = 1'b1;
    finish_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_finish_valid", 64'(finish_valid_o), 64'd1);
    chk("t5_start_ready", 64'(start_ready_o), 64'd1);
    chk("t5_dispatch_unit3", 64'(unit_start_valid_o), 64'b1000);
    chk("t5_inflight_before", 64'(inflight_cnt_o), 64'd3);
    sbq.push_back('{64'hDDDD_0000_0000_0000, 5'b01000, 3});
    @(posedge clk);
    #1;
    start_valid_i = 1'b0;
    @(negedge clk);
    chk("t5_inflight_after", 64'(inflight_cnt_o), 64'd3);
    chk("t5_next_head", 64'(unit_finish_ready_o), 64'b0010);
    chk("t5_next_not_valid", 64'(finish_valid_o), 64'd0);
    drain("t5");

    // Flush with three in flight, then a stray finish
    do_reset();
    finish_ready_i = 1'b0;
    issue(64'h0F0F_0000_0000_0000, 5'b00001, 0, 1, 1'b0);
    issue(64'h0E0E_0000_0000_0000, 5'b00001, 1, 30, 1'b0);
    issue(64'h0D0D_0000_0000_0000, 5'b00001, 2, 30, 1'b0);
    @(negedge clk);
    chk("t6_inflight_three", 64'(inflight_cnt_o), 64'd3);
    chk("t6_head_valid", 64'(finish_valid_o), 64'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    start_valid_i = 1'b1;
    nlat = 2;
    @(negedge clk);
    chk("t6_flush_start_ready", 64'(start_ready_o), 64'd0);
    chk("t6_flush_finish_valid", 64'(finish_valid_o), 64'd0);
    chk("t6_flush_bcast", 64'(unit_flush_o), 64'd1);
    chk("t6_flush_no_dispatch", 64'(unit_start_valid_o), 64'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    start_valid_i = 1'b0;
    finish_ready_i = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("t6_post_inflight", 64'(inflight_cnt_o), 64'd0);
    chk("t6_post_finish_valid", 64'(finish_valid_o), 64'd0);
    chk("t6_post_err", 64'(protocol_err_o), 64'd0);
    @(posedge clk);
    #1;
    issue(64'h0C0C_0000_0000_0000, 5'b00100, 0, 2, 1'b0);
    drain("t6");
    stray = 4'b0010;
    @(negedge clk);
    chk("t6_err_registered", 64'(protocol_err_o), 64'd0);
    @(posedge clk);
    #1;
    stray = 4'b0000;
    @(negedge clk);
    chk("t6_err_set", 64'(protocol_err_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(protocol_err_o), 64'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("t6_err_survives_flush", 64'(protocol_err_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_err_async_clear", 64'(protocol_err_o), 64'd0);
    chk("t6_inflight_async_clear", 64'(inflight_cnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
